// File: rtl/pipe_stage_if.sv
// ============================================================================
// Module      : pipe_stage_if
// Description : Handshake bundle between a producer stage, pipe_stage and
//               the consuming stage. master = testbench/upstream side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_stage_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 16
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [CNT_WIDTH-1:0]  stall_count;

    modport master (
        output flush,
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  stall_count
    );

    modport slave (
        input  flush,
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output stall_count
    );
endinterface

`default_nettype wire

// File: rtl/pipe_stage.sv
// ============================================================================
// Module      : pipe_stage
// Description : Elastic valid/ready pipeline register with synchronous flush
//               and a saturating back-pressure counter. Define PIPE_SKID_EN
//               for the two-entry skid build with a registered in_ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic        clk,
    input  logic        reset,
    pipe_stage_if.slave bus
);

    generate
        if (DATA_WIDTH <= 0) begin : g_bad_data_width
            $error("pipe_stage: DATA_WIDTH must be > 0");
        end
        if (CNT_WIDTH <= 0) begin : g_bad_cnt_width
            $error("pipe_stage: CNT_WIDTH must be > 0");
        end
    endgenerate

    localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_main;
    logic [CNT_WIDTH-1:0]  r_stall_cnt;
    logic                  w_in_ready;
    logic                  w_in_xfer;
    logic                  w_out_xfer;

`ifdef PIPE_SKID_EN
    logic                  r_in_ready;
    logic [DATA_WIDTH-1:0] r_skid;

    // Ready comes straight from a flop so out_ready never reaches upstream.
    assign w_in_ready = r_in_ready;
`else
    assign w_in_ready = ~r_out_valid | bus.out_ready;
`endif

    assign w_in_xfer  = bus.in_valid & w_in_ready;
    assign w_out_xfer = r_out_valid & bus.out_ready;

`ifdef PIPE_SKID_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_main      <= '0;
            r_skid      <= '0;
        end else if (bus.flush) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        r_state     <= ST_FULL;
                        r_out_valid <= 1'b1;
                        r_main      <= bus.in_data;
                    end
                end
                ST_FULL: begin
                    if (w_in_xfer && w_out_xfer) begin
                        r_main <= bus.in_data;
                    end else if (w_in_xfer) begin
                        r_state    <= ST_SKID;
                        r_skid     <= bus.in_data;
                        r_in_ready <= 1'b0;
                    end else if (w_out_xfer) begin
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                ST_SKID: begin
                    if (w_out_xfer) begin
                        r_state    <= ST_FULL;
                        r_main     <= r_skid;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_main      <= '0;
        end else if (bus.flush) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        r_state     <= ST_FULL;
                        r_out_valid <= 1'b1;
                        r_main      <= bus.in_data;
                    end
                end
                ST_FULL: begin
                    // An input transfer while FULL implies out_ready, so it
                    // always coincides with an output transfer.
                    if (w_out_xfer) begin
                        if (w_in_xfer) begin
                            r_main <= bus.in_data;
                        end else begin
                            r_state     <= ST_EMPTY;
                            r_out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end
`endif

    // Performance counter: only reset clears it, flush leaves it untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (r_out_valid && !bus.out_ready && (r_stall_cnt != c_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_data    = r_main;
    assign bus.stall_count = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage.sv
// ============================================================================
// Module      : tb_pipe_stage
// Description : Scoreboard bench for pipe_stage (either build, PIPE_SKID_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage;

    localparam int DW = 32;
    localparam int CW = 4;
`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic clk;
    logic reset;

    pipe_stage_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    pipe_stage #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] q[$];
    logic [CW-1:0] m_cnt = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_ready();
        if (SKID) return (q.size() < 2);
        return (q.size() == 0) || bus.out_ready;
    endfunction

    // Reference model: compare current outputs, then advance past the next edge.
    always @(negedge clk) begin
        if (!reset) begin
            q.delete();
            m_cnt = '0;
        end else begin
            logic rdy;
            logic vld;
            rdy = exp_ready();
            vld = (q.size() != 0);
            chk("out_valid", bus.out_valid, vld);
            chk("in_ready", bus.in_ready, rdy);
            chk("stall_count", bus.stall_count, m_cnt);
            if (vld) chk("out_data", bus.out_data, q[0]);
            if (vld && !bus.out_ready && m_cnt != '1) m_cnt = m_cnt + 1'b1;
            if (vld && bus.out_ready) void'(q.pop_front());
            if (bus.flush) q.delete();
            else if (bus.in_valid && rdy) q.push_back(bus.in_data);
        end
    end

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        bus.flush     = fl;
    endtask

    initial begin
        reset         = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_stall", bus.stall_count, 0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Stream 1,2,3 with the consumer always ready
        drive(1'b1, 32'h1, 1'b1, 1'b0);
        drive(1'b1, 32'h2, 1'b1, 1'b0);
        drive(1'b1, 32'h3, 1'b1, 1'b0);
        repeat (3) drive(1'b0, '0, 1'b1, 1'b0);
        #1 chk("stream_stall", bus.stall_count, 0);

        // Back-pressure: A then B while stalled, then release
        drive(1'b1, 32'hA, 1'b0, 1'b0);
        drive(1'b1, 32'hB, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        #1 chk("bp_in_ready", bus.in_ready, 0);
        repeat (4) drive(1'b0, '0, 1'b1, 1'b0);

        // Flush while holding A/B, with C offered in the flush cycle
        drive(1'b1, 32'hA, 1'b0, 1'b0);
        drive(1'b1, 32'hB, 1'b0, 1'b0);
        drive(1'b1, 32'hC, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0);
        #1;
        chk("flush_valid", bus.out_valid, 0);
        chk("flush_ready", bus.in_ready, 1);
        repeat (3) drive(1'b0, '0, 1'b1, 1'b0);

        // Counter saturation, then flush leaves it saturated
        drive(1'b1, 32'h5, 1'b0, 1'b0);
        repeat (20) drive(1'b0, '0, 1'b0, 1'b0);
        #1 chk("sat_cnt", bus.stall_count, 4'hF);
        drive(1'b0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0);
        #1 chk("sat_after_flush", bus.stall_count, 4'hF);

        // Asynchronous reset between edges while holding data
        drive(1'b1, 32'h6, 1'b0, 1'b0);
        repeat (3) drive(1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("areset_valid", bus.out_valid, 0);
        chk("areset_data", bus.out_data, 0);
        chk("areset_cnt", bus.stall_count, 0);
        @(posedge clk);
        #1 reset = 1'b1;

        // in_ready path from out_ready
        drive(1'b1, 32'h7, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        #1 chk("ready_stalled", bus.in_ready, SKID ? 1 : 0);
        drive(1'b0, '0, 1'b1, 1'b0);
        #1 chk("ready_released", bus.in_ready, 1);
        repeat (2) drive(1'b0, '0, 1'b1, 1'b0);

        // Random traffic with occasional flush
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), DW'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
        end
        repeat (5) drive(1'b0, '0, 1'b1, 1'b0);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
